// File: rtl/pos_move_ctrl.sv
// -----------------------------------------------------------------------------
// pos_move_ctrl
//
// Sequencing controller for the 2-D cursor position datapath. A 4-bit move
// command is accepted over a valid/ready handshake. The candidate coordinate
// is computed with a 5-bit add/subtract, range-checked against MAX_POS and
// committed to the X/Y position registers. After each commit a programmable
// hold-off (GAP cycles) keeps cmd_ready low to rate-limit moves.
//
// Command word:
//   cmd[0]   : 1 = X axis, 0 = Y axis
//   cmd[1]   : 1 = subtract, 0 = add
//   cmd[3:2] : step magnitude 0..3 (0 is a legal no-op)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high reset (aborts any command)
//   cmd_valid   in   command present
//   cmd[3:0]    in   command word, sampled only at the handshake edge
//   cmd_ready   out  high in IDLE (and not in reset)
//   pos_x[3:0]  out  registered X coordinate
//   pos_y[3:0]  out  registered Y coordinate
//   busy        out  high in CALC, COMMIT and GAP
//   done        out  one-cycle pulse when a command completes
//   err         out  one-cycle pulse with done when the result was out of range
//   move_count  out  commits that changed a coordinate, wraps 255 -> 0
//
// Build option:
//   POS_MOVE_SATURATE_EN  defined   : out-of-range results clamp to MAX_POS
//                                     (add) or 0 (subtract) and are written.
//                         undefined : out-of-range commands are rejected and
//                                     the position is left unchanged.
//   err pulses for an out-of-range result in both builds.
// -----------------------------------------------------------------------------
module pos_move_ctrl #(
  parameter logic [3:0] X_INIT  = 4'd0,
  parameter logic [3:0] Y_INIT  = 4'd0,
  parameter logic [3:0] MAX_POS = 4'd15,
  parameter int unsigned GAP    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [3:0] cmd,
  output logic       cmd_ready,
  output logic [3:0] pos_x,
  output logic [3:0] pos_y,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] move_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  // Gap counter preload; the GAP state is never entered when GAP is 0.
  localparam logic [7:0] GAP_LOAD = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t      r_state;
  state_t      w_next_state;

  logic [3:0]  r_cmd;
  logic [4:0]  r_result;
  logic        r_out_of_range;
  logic [3:0]  r_pos_x;
  logic [3:0]  r_pos_y;
  logic [7:0]  r_gap_cnt;
  logic [7:0]  r_move_count;
  logic        r_done;
  logic        r_err;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic        w_accept;
  logic [3:0]  w_operand;
  logic [4:0]  w_step;
  logic [4:0]  w_result;
  logic        w_out_of_range;
  logic        w_commit_en;
  logic [3:0]  w_commit_val;
  logic        w_changed;

  // cmd_ready is a function of state only; reset forces it low so a handshake
  // coincident with reset is never reported as accepted.
  assign cmd_ready = (r_state == ST_IDLE) && !reset;
  assign w_accept  = cmd_ready && cmd_valid;

  // The selected axis is read from the live position registers. The same
  // selection feeds both the CALC computation and the COMMIT change test;
  // the position cannot move between the two since only COMMIT writes it.
  assign w_operand = r_cmd[0] ? r_pos_x : r_pos_y;
  assign w_step    = {3'b000, r_cmd[3:2]};

  // A 5-bit result exposes both carry (add past 15) and borrow (subtract
  // below 0) in bit 4, so one test covers both wrap cases.
  assign w_result       = r_cmd[1] ? ({1'b0, w_operand} - w_step)
                                   : ({1'b0, w_operand} + w_step);
  assign w_out_of_range = w_result[4] || (w_result[3:0] > MAX_POS);

`ifdef POS_MOVE_SATURATE_EN
  // Clamp toward the bound the move was heading for.
  assign w_commit_en  = 1'b1;
  assign w_commit_val = !r_out_of_range ? r_result[3:0]
                      : (r_cmd[1] ? 4'd0 : MAX_POS);
`else
  assign w_commit_en  = !r_out_of_range;
  assign w_commit_val = r_result[3:0];
`endif

  // Only a write that actually moves the cursor is counted, so step 0 and
  // a clamp that lands on the current value leave move_count alone.
  assign w_changed = w_commit_en && (w_commit_val != w_operand);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the order of statements does not matter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state and state-decoded outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_accept) begin
          w_next_state = ST_CALC;
        end
      end
      ST_CALC: begin
        w_next_state = ST_COMMIT;
      end
      ST_COMMIT: begin
        w_next_state = (GAP > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        // Leave in the cycle after the counter has reached zero.
        if (r_gap_cnt == 8'd0) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd          <= 4'd0;
      r_result       <= 5'd0;
      r_out_of_range <= 1'b0;
      r_pos_x        <= X_INIT;
      r_pos_y        <= Y_INIT;
      r_gap_cnt      <= 8'd0;
      r_move_count   <= 8'd0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      // done/err are single-cycle pulses unless COMMIT re-asserts them.
      r_done <= 1'b0;
      r_err  <= 1'b0;

      if (w_accept) begin
        r_cmd <= cmd;
      end

      if (r_state == ST_CALC) begin
        r_result       <= w_result;
        r_out_of_range <= w_out_of_range;
      end

      if (r_state == ST_COMMIT) begin
        if (w_commit_en) begin
          if (r_cmd[0]) begin
            r_pos_x <= w_commit_val;
          end else begin
            r_pos_y <= w_commit_val;
          end
        end
        if (w_changed) begin
          r_move_count <= r_move_count + 8'd1;
        end
        r_done    <= 1'b1;
        r_err     <= r_out_of_range;
        r_gap_cnt <= GAP_LOAD;
      end

      if ((r_state == ST_GAP) && (r_gap_cnt != 8'd0)) begin
        r_gap_cnt <= r_gap_cnt - 8'd1;
      end
    end
  end

  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign done       = r_done;
  assign err        = r_err;
  assign move_count = r_move_count;

endmodule

// File: tb/tb_pos_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pos_move_ctrl
//
// Directed bench for pos_move_ctrl. Two instances share one clock:
//   u_a : X_INIT=3, Y_INIT=5, MAX_POS=9,  GAP=4  (reset, add, bounds, abort)
//   u_b : X_INIT=0, Y_INIT=0, MAX_POS=15, GAP=0  (back-to-back, step 0)
// Inputs are driven at the falling edge and outputs sampled there, away from
// the rising edge where the design updates. Expected values for the
// out-of-range cases follow POS_MOVE_SATURATE_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pos_move_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic       a_reset;
  logic       a_valid;
  logic [3:0] a_cmd;
  logic       a_ready;
  logic [3:0] a_pos_x;
  logic [3:0] a_pos_y;
  logic       a_busy;
  logic       a_done;
  logic       a_err;
  logic [7:0] a_cnt;

  // Instance B signals
  logic       b_reset;
  logic       b_valid;
  logic [3:0] b_cmd;
  logic       b_ready;
  logic [3:0] b_pos_x;
  logic [3:0] b_pos_y;
  logic       b_busy;
  logic       b_done;
  logic       b_err;
  logic [7:0] b_cnt;

  pos_move_ctrl #(
    .X_INIT(4'd3), .Y_INIT(4'd5), .MAX_POS(4'd9), .GAP(4)
  ) u_a (
    .clk(clk), .reset(a_reset), .cmd_valid(a_valid), .cmd(a_cmd),
    .cmd_ready(a_ready), .pos_x(a_pos_x), .pos_y(a_pos_y), .busy(a_busy),
    .done(a_done), .err(a_err), .move_count(a_cnt)
  );

  pos_move_ctrl #(
    .X_INIT(4'd0), .Y_INIT(4'd0), .MAX_POS(4'd15), .GAP(0)
  ) u_b (
    .clk(clk), .reset(b_reset), .cmd_valid(b_valid), .cmd(b_cmd),
    .cmd_ready(b_ready), .pos_x(b_pos_x), .pos_y(b_pos_y), .busy(b_busy),
    .done(b_done), .err(b_err), .move_count(b_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Instance A: issue one command and observe it until cmd_ready returns.
  // Sample 1 is the falling edge right after the accept edge E0.
  // ---------------------------------------------------------------------------
  task automatic run_a(input logic [3:0] c, output int low, output int dones,
                       output int done_idx, output int err_at_done,
                       output int x_mid, output int y_mid);
    int n;
    int s;
    @(negedge clk);
    a_valid = 1'b1;
    a_cmd   = c;
    n = 0;
    while (!a_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!a_ready) check("accept_timeout", int'(a_ready), 1);
    @(negedge clk);
    a_valid     = 1'b0;
    a_cmd       = 4'h0;
    low         = 0;
    dones       = 0;
    done_idx    = 0;
    err_at_done = 0;
    x_mid       = -1;
    y_mid       = -1;
    s           = 1;
    while (s < 300) begin
      if (a_done) begin
        dones++;
        done_idx    = s;
        err_at_done = int'(a_err);
      end
      if (s == 2) begin
        x_mid = int'(a_pos_x);
        y_mid = int'(a_pos_y);
      end
      if (a_ready) break;
      low++;
      s++;
      @(negedge clk);
    end
    if (s >= 300) check("ready_timeout", int'(a_ready), 1);
  endtask

  int exp_x;
  int exp_y;
  int exp_cnt;

  // Run one command on A and check every observable against the model state.
  task automatic do_a(input string tag, input logic [3:0] c, input int nx,
                      input int ny, input int nerr, input int inc);
    int low, dones, didx, e, xm, ym;
    run_a(c, low, dones, didx, e, xm, ym);
    check({tag, "_x_before_commit"}, xm, exp_x);
    check({tag, "_y_before_commit"}, ym, exp_y);
    exp_x   = nx;
    exp_y   = ny;
    exp_cnt = (exp_cnt + inc) % 256;
    check({tag, "_done_pulses"}, dones, 1);
    check({tag, "_done_latency"}, didx, 3);
    check({tag, "_err"}, e, nerr);
    check({tag, "_ready_low_cycles"}, low, 6);
    check({tag, "_pos_x"}, int'(a_pos_x), exp_x);
    check({tag, "_pos_y"}, int'(a_pos_y), exp_y);
    check({tag, "_move_count"}, int'(a_cnt), exp_cnt);
  endtask

  // ---------------------------------------------------------------------------
  // Instance B monitor: records accept cycles and the state at each done.
  // Runs slightly after the falling edge so it sees that edge's drives.
  // ---------------------------------------------------------------------------
  int b_cyc   = 0;
  int b_nacc  = 0;
  int b_ndone = 0;
  int b_acc   [8];
  int bd_pos  [8];
  int bd_err  [8];

  always @(negedge clk) begin
    #2;
    if (b_valid && b_ready) begin
      if (b_nacc < 8) b_acc[b_nacc] = b_cyc;
      b_nacc++;
    end
    if (b_done) begin
      if (b_ndone < 8) begin
        bd_pos[b_ndone] = int'(b_pos_x);
        bd_err[b_ndone] = int'(b_err);
      end
      b_ndone++;
    end
    b_cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    a_reset = 1'b1; a_valid = 1'b0; a_cmd = 4'h0;
    b_reset = 1'b1; b_valid = 1'b0; b_cmd = 4'h0;

    // ---------------- Reset ----------------
    repeat (3) @(negedge clk);
    a_valid = 1'b1;                      // handshake attempt during reset
    a_cmd   = 4'b1101;
    check("reset_ready_low", int'(a_ready), 0);
    check("reset_busy_low", int'(a_busy), 0);
    @(negedge clk);
    a_valid = 1'b0;
    a_reset = 1'b0;
    b_reset = 1'b0;
    #1;
    check("post_reset_ready", int'(a_ready), 1);
    check("post_reset_pos_x", int'(a_pos_x), 3);
    check("post_reset_pos_y", int'(a_pos_y), 5);
    check("post_reset_count", int'(a_cnt), 0);
    check("post_reset_done", int'(a_done), 0);
    check("post_reset_err", int'(a_err), 0);
    check("post_reset_b_ready", int'(b_ready), 1);
    exp_x = 3; exp_y = 5; exp_cnt = 0;

    // ---------------- Add / bounds on A ----------------
    do_a("add_x3", 4'b1101, 6, 5, 0, 1);
    do_a("add_x2", 4'b1001, 8, 5, 0, 1);
`ifdef POS_MOVE_SATURATE_EN
    do_a("upper_bound", 4'b1001, 9, 5, 1, 1);
`else
    do_a("upper_bound", 4'b1001, 8, 5, 1, 0);
`endif
    do_a("sub_y3", 4'b1110, exp_x, 2, 0, 1);
    do_a("sub_y1", 4'b0110, exp_x, 1, 0, 1);
`ifdef POS_MOVE_SATURATE_EN
    do_a("underflow", 4'b1010, exp_x, 0, 1, 1);
    // Clamp lands on the current value: err, but no count change.
    do_a("clamp_same", 4'b0110, exp_x, 0, 1, 0);
`else
    do_a("underflow", 4'b1010, exp_x, 1, 1, 0);
    do_a("sub_to_zero", 4'b0110, exp_x, 0, 0, 1);
`endif

    // ---------------- Mid-operation reset on A ----------------
    @(negedge clk);
    a_valid = 1'b1;
    a_cmd   = 4'b0101;
    n = 0;
    while (!a_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);                      // after E0: CALC
    a_valid = 1'b0;
    @(negedge clk);                      // after E1: COMMIT
    check("abort_busy_in_commit", int'(a_busy), 1);
    a_reset = 1'b1;
    @(negedge clk);                      // after E2: commit suppressed
    check("abort_no_done", int'(a_done), 0);
    check("abort_pos_x", int'(a_pos_x), 3);
    check("abort_pos_y", int'(a_pos_y), 5);
    check("abort_count", int'(a_cnt), 0);
    @(negedge clk);
    check("abort_no_done_late", int'(a_done), 0);
    a_reset = 1'b0;
    exp_x = 3; exp_y = 5; exp_cnt = 0;
    do_a("after_abort", 4'b1101, 6, 5, 0, 1);

    // ---------------- Back-to-back on B (GAP = 0) ----------------
    @(negedge clk);
    b_valid = 1'b1;
    b_cmd   = 4'b0101;
    n = 0;
    while (b_nacc < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    b_cmd = 4'b0001;                     // step 0 for the fourth command
    n = 0;
    while (b_nacc < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    b_valid = 1'b0;
    n = 0;
    while (b_ndone < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    check("b2b_accepts", b_nacc, 4);
    check("b2b_dones", b_ndone, 4);
    if (b_nacc >= 4) begin
      check("b2b_spacing_1", b_acc[1] - b_acc[0], 3);
      check("b2b_spacing_2", b_acc[2] - b_acc[1], 3);
      check("b2b_spacing_3", b_acc[3] - b_acc[2], 3);
    end
    if (b_ndone >= 4) begin
      check("b2b_pos_1", bd_pos[0], 1);
      check("b2b_pos_2", bd_pos[1], 2);
      check("b2b_pos_3", bd_pos[2], 3);
      check("step0_pos", bd_pos[3], 3);
      check("b2b_err_1", bd_err[0], 0);
      check("step0_err", bd_err[3], 0);
    end
    check("step0_count", int'(b_cnt), 3);
    check("b_pos_y_untouched", int'(b_pos_y), 0);
    check("b_idle_ready", int'(b_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pos_move_ctrl.md
# pos_move_ctrl

Sequencing controller for the 2-D cursor position datapath: accepts 4-bit move commands over a valid/ready handshake, computes the candidate coordinate with the 5-bit add/subtract rule, range-checks it, and commits it to the X/Y position registers. Sits between the switch/button front end and the display driver. After each move, a programmable hold-off gap rate-limits accepted moves.

## Interface
- `X_INIT`, 0: X position loaded on reset (0..MAX_POS).
- `Y_INIT`, 0: Y position loaded on reset (0..MAX_POS).
- `MAX_POS`, 15: inclusive upper coordinate bound (1..15).
- `GAP`, 4: idle cycles after each commit with `cmd_ready` low (0..255).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd`  in  4  command word:
  - `[0]` = 1 selects X axis, 0 selects Y axis.
  - `[1]` = 1 subtract, 0 add.
  - `[3:2]` = step magnitude, 0..3.
- `cmd_ready`  out  1  controller can accept a command this cycle.
- `pos_x`  out  4  registered X coordinate.
- `pos_y`  out  4  registered Y coordinate.
- `busy`  out  1  high in CALC, COMMIT and GAP.
- `done`  out  1  one-cycle pulse when a command completes.
- `err`  out  1  one-cycle pulse, coincident with `done`, when the result was out of range.
- `move_count`  out  8  count of commits that changed a coordinate; wraps from 255 to 0.

## Operation
- **FSM states:** IDLE, CALC, COMMIT, GAP.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid & cmd_ready`, capture `cmd` and go to CALC.
  - `cmd` is sampled only at the handshake edge.
- **CALC**
  - Select operand `a` = `pos_x` if `cmd[0]`, else `pos_y`.
  - Compute the 5-bit result r = {1'b0,a} + {3'b0,step}, or the 5-bit two's-complement {1'b0,a} − {3'b0,step} when subtracting.
  - Out of range when r[4] = 1 (carry or borrow) or r[3:0] > MAX_POS.
  - Register r and the range flag; go to COMMIT.
- **COMMIT**
  - In range: write r[3:0] to the selected axis; the other axis is unchanged.
  - Out of range: handling is set by Configuration.
  - Increment `move_count` only if the written value differs from the old one.
  - Go to GAP if GAP > 0, else go to IDLE.
- **GAP**
  - An 8-bit counter loads GAP−1 on entry and decrements each cycle.
  - Go to IDLE in the cycle after the counter reaches 0.
- **Step 0:** a legal no-op. It completes with `done`, no `err`, and no count change.
- **Reset values:**
  - `pos_x` = X_INIT, `pos_y` = Y_INIT.
  - `cmd_ready` = 0 during reset; state is IDLE, so `cmd_ready` = 1 in the first cycle after reset deasserts.
  - `busy` = 0, `done` = 0, `err` = 0, `move_count` = 0, gap counter = 0.
- **Reset mid-operation:** abort from any state. Discard the in-flight command without a commit or `done`, and reload all reset values.

## Timing
- **Acceptance:** at edge E0 (`cmd_valid & cmd_ready`). CALC occupies E0→E1; COMMIT occupies E1→E2.
- **Commit visibility:** the new `pos_x`/`pos_y` are visible after E2. `done` and `err` are high for exactly the E2→E3 cycle.
- **Command-to-position latency:** 2 cycles.
- **Throughput:** the next accept is possible at E2 + GAP + 1, i.e. one command per GAP + 3 cycles. With GAP = 0, one per 3 cycles.
- **`cmd_ready`:** combinational from state (IDLE only); never depends on `cmd_valid`. `cmd_valid` held high while not ready is simply not accepted, and no command is lost or duplicated.
- **Simultaneous events:** `reset` has priority over everything. A handshake in the same cycle as `reset` is ignored.

## Configuration
- Macro `POS_MOVE_SATURATE_EN`.
- **Defined:**
  - An out-of-range result clamps to MAX_POS (add) or 0 (subtract) and is written.
  - `err` pulses.
  - `move_count` increments if the clamped value differs from the old value.
- **Undefined:**
  - An out-of-range command is rejected: position is unchanged and `move_count` is unchanged.
  - `err` pulses with `done`.

## Test plan
- **Reset:** reset with X_INIT = 3, Y_INIT = 5 → `pos_x` = 3, `pos_y` = 5, `move_count` = 0, `cmd_ready` = 1 in the first cycle after reset deasserts.
- **Add X:** from (3,5), GAP = 4, `cmd` = 4'b1101 (X, add 3) → `pos_x` = 6 two cycles after accept, `done` for 1 cycle, `cmd_ready` low for 6 cycles, `move_count` = 1.
- **Subtract underflow:** from `pos_y` = 1, `cmd` = 4'b1010 (Y, subtract 2) → r = 5'b11111. Defined: `pos_y` = 0 with `err`. Undefined: `pos_y` = 1 with `err`.
- **Upper bound:** MAX_POS = 9, `pos_x` = 8, `cmd` = 4'b1001 (X, add 2) → out of range. Defined: `pos_x` = 9 with `err`. Undefined: `pos_x` = 8 with `err`.
- **Back-to-back:** `cmd_valid` held high with GAP = 0, `cmd` = 4'b0101 (X, add 1) ×3 → accepts exactly every 3 cycles, `pos_x` goes 0→1→2→3. Then `cmd` = 4'b0001 (X, step 0) → `done`, no `err`, `move_count` unchanged.
- **Mid-operation reset:** assert `reset` in the COMMIT cycle → no `done`, positions return to X_INIT/Y_INIT, and the next command is accepted normally.
